mem_access_stage: RTL and testbench

//   MEM pipeline stage directly downstream of the EX/MEM register. Consumes its

---
 rtl/mem_access_stage.sv | 137 +++++++++++++
 tb/tb_mem_access_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: passes ALU results through in one cycle and performs loads and stores
// over a req/ack memory handshake. It stalls upstream and aborts an access that gets no ack in time.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        regwrite_i,
  input  logic        memtoreg_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_addr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        err_o,
  output logic        regwrite_o,
  output logic        memtoreg_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] mem_data_o,
  output logic [4:0]  rd_addr_o
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             w_op;
  logic             w_timeout;
  logic             w_stall;

  logic             r_pendRegwrite;
  logic             r_pendMemtoreg;
  logic             r_pendWe;
  logic [31:0]      r_pendAlu;
  logic [31:0]      r_pendWdata;
  logic [4:0]       r_pendRd;
  logic [CNT_W-1:0] r_cnt;

  logic             r_err;
  logic             r_regwrite;
  logic             r_memtoreg;
  logic [31:0]      r_aluResult;
  logic [31:0]      r_memData;
  logic [4:0]       r_rdAddr;

  // Ack beats timeout; a timed-out access releases stall so the faulting instruction is dropped.
  always_comb begin
    w_nextState = r_state;
    w_op        = memread_i | memwrite_i;
    w_timeout   = 1'b0;
    w_stall     = 1'b0;
    if (r_state == IDLE) begin
      w_stall = w_op;
      if (w_op) w_nextState = ACCESS;
    end else begin
      w_timeout = !mem_ack_i && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
      w_stall   = !mem_ack_i && !w_timeout;
      if (mem_ack_i || w_timeout) w_nextState = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pendRegwrite <= 1'b0;
      r_pendMemtoreg <= 1'b0;
      r_pendWe       <= 1'b0;
      r_pendAlu      <= '0;
      r_pendWdata    <= '0;
      r_pendRd       <= '0;
      r_cnt          <= '0;
      r_err          <= 1'b0;
      r_regwrite     <= 1'b0;
      r_memtoreg     <= 1'b0;
      r_aluResult    <= '0;
      r_memData      <= '0;
      r_rdAddr       <= '0;
    end else begin
      r_regwrite  <= 1'b0;
      r_memtoreg  <= 1'b0;
      r_aluResult <= '0;
      r_memData   <= '0;
      r_rdAddr    <= '0;
      if (r_state == IDLE) begin
        if (!w_op) begin
          r_regwrite  <= regwrite_i;
          r_memtoreg  <= memtoreg_i;
          r_aluResult <= alu_result_i;
          r_rdAddr    <= rd_addr_i;
        end else begin
          r_pendRegwrite <= regwrite_i;
          r_pendMemtoreg <= memtoreg_i;
          r_pendWe       <= memwrite_i;
          r_pendAlu      <= alu_result_i;
          r_pendWdata    <= rs2_data_i;
          r_pendRd       <= rd_addr_i;
          r_cnt          <= '0;
        end
      end else if (mem_ack_i) begin
        r_regwrite  <= r_pendRegwrite;
        r_memtoreg  <= r_pendMemtoreg;
        r_aluResult <= r_pendAlu;
        r_memData   <= r_pendWe ? 32'd0 : mem_rdata_i;
        r_rdAddr    <= r_pendRd;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign mem_req_o    = (r_state == ACCESS);
  assign mem_we_o     = r_pendWe;
  assign mem_addr_o   = {r_pendAlu[31:2], 2'b00};
  assign mem_wdata_o  = r_pendWdata;
  assign stall_o      = w_stall;
  assign err_o        = r_err;
  assign regwrite_o   = r_regwrite;
  assign memtoreg_o   = r_memtoreg;
  assign alu_result_o = r_aluResult;
  assign mem_data_o   = r_memData;
  assign rd_addr_o    = r_rdAddr;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver feeds an instruction stream and a memory responder acks.
// A monitor matches every non-bubble WB output against what the instruction-level model predicts.
module tb_mem_access_stage;

  localparam int T = 6;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        regwrite_i = 1'b0;
  logic        memtoreg_i = 1'b0;
  logic        memread_i = 1'b0;
  logic        memwrite_i = 1'b0;
  logic [31:0] alu_result_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        stall_o;
  logic        err_o;
  logic        regwrite_o;
  logic        memtoreg_o;
  logic [31:0] alu_result_o;
  logic [31:0] mem_data_o;
  logic [4:0]  rd_addr_o;

  mem_access_stage #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .regwrite_i(regwrite_i), .memtoreg_i(memtoreg_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
    .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .err_o(err_o),
    .regwrite_o(regwrite_o), .memtoreg_o(memtoreg_o), .alu_result_o(alu_result_o),
    .mem_data_o(mem_data_o), .rd_addr_o(rd_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rw;
    logic        mtr;
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  rd;
  } wbExp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
  } memExp_t;

  wbExp_t  expQ[$];
  memExp_t memQ[$];
  int      checks = 0;
  int      failures = 0;
  logic    expErr = 1'b0;
  logic    respEnable = 1'b0;

  function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
    end
  endfunction

  // Issue one instruction at the upstream boundary and hold it until the stage accepts it.
  task automatic applyStimulus(input logic rw, input logic mtr, input logic mr, input logic mw,
                               input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                               input int delay, input logic [31:0] rdata);
    wbExp_t  e;
    memExp_t m;
    int      expStall;
    int      stallCnt;
    logic    done;
    regwrite_i = rw; memtoreg_i = mtr; memread_i = mr; memwrite_i = mw;
    alu_result_i = alu; rs2_data_i = rs2; rd_addr_i = rd;
    e.rw = rw; e.mtr = mtr; e.alu = alu; e.rd = rd; e.data = 32'd0;
    expStall = 0;
    if (mr || mw) begin
      m.we = mw; m.addr = alu & 32'hFFFF_FFFC; m.wdata = rs2; m.delay = delay; m.rdata = rdata;
      memQ.push_back(m);
      expStall = 1 + ((delay < T - 1) ? delay : T - 1);
      if (delay <= T - 1) begin
        if (!mw) e.data = rdata;
        expQ.push_back(e);
      end
    end else begin
      expQ.push_back(e);
    end
    stallCnt = 0;
    done = 1'b0;
    for (int c = 0; c < T + 6; c++) begin
      @(negedge clk_i);
      if (!stall_o) begin
        done = 1'b1;
        break;
      end
      stallCnt++;
    end
    checkOutput("stall_released", 32'(done), 32'd1);
    checkOutput("stall_cycles", 32'(stallCnt), 32'(expStall));
    @(posedge clk_i);
    #1;
    if ((mr || mw) && delay > T - 1) expErr = 1'b1;
    checkOutput("err_flag", 32'(err_o), 32'(expErr));
  endtask

  // Memory responder: acks each request after its scheduled number of wait cycles.
  initial begin : responder
    memExp_t cur;
    int      reqCycles;
    int      expCycles;
    reqCycles = 0;
    cur = '{we: 1'b0, addr: 32'd0, wdata: 32'd0, delay: 0, rdata: 32'd0};
    forever begin
      @(posedge clk_i);
      #1;
      if (!respEnable) begin
        reqCycles = 0;
      end else begin
        mem_ack_i = 1'b0;
        mem_rdata_i = $urandom;
        if (mem_req_o) begin
          if (reqCycles == 0) begin
            if (memQ.size() == 0) begin
              checkOutput("unexpected_req", 32'd1, 32'd0);
              cur = '{we: 1'b0, addr: 32'd0, wdata: 32'd0, delay: 0, rdata: 32'd0};
            end else begin
              cur = memQ.pop_front();
            end
          end
          checkOutput("mem_we", 32'(mem_we_o), 32'(cur.we));
          checkOutput("mem_addr", mem_addr_o, cur.addr);
          if (cur.we) checkOutput("mem_wdata", mem_wdata_o, cur.wdata);
          if (reqCycles == cur.delay) begin
            mem_ack_i = 1'b1;
            mem_rdata_i = cur.rdata;
          end
          reqCycles++;
        end else if (reqCycles != 0) begin
          expCycles = (cur.delay + 1 < T) ? cur.delay + 1 : T;
          checkOutput("req_cycles", 32'(reqCycles), 32'(expCycles));
          reqCycles = 0;
        end
      end
    end
  end

  // Monitor: any non-bubble WB output must be the next committed instruction.
  initial begin : monitor
    wbExp_t e;
    forever begin
      @(negedge clk_i);
      if (regwrite_o || memtoreg_o || alu_result_o != 0 || mem_data_o != 0 || rd_addr_o != 0) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_commit", alu_result_o, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("wb_regwrite", 32'(regwrite_o), 32'(e.rw));
          checkOutput("wb_memtoreg", 32'(memtoreg_o), 32'(e.mtr));
          checkOutput("wb_alu", alu_result_o, e.alu);
          checkOutput("wb_memdata", mem_data_o, e.data);
          checkOutput("wb_rd", 32'(rd_addr_o), 32'(e.rd));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic randomInstr();
    int          kind;
    int          r;
    int          delay;
    logic        mr;
    logic        mw;
    kind = $urandom_range(9, 0);
    mr = (kind >= 4 && kind <= 6) || kind == 9;
    mw = (kind >= 7);
    r = $urandom_range(9, 0);
    if (r == 7)      delay = T + $urandom_range(4, 0);
    else if (r == 6) delay = T - 1;
    else             delay = $urandom_range(2, 0);
    applyStimulus(1'($urandom), 1'($urandom), mr, mw, $urandom | 32'h100, $urandom,
                  5'($urandom), delay, $urandom);
  endtask

  initial begin : stimulus
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    checkOutput("reset_req", 32'(mem_req_o), 32'd0);
    checkOutput("reset_stall", 32'(stall_o), 32'd0);
    checkOutput("reset_err", 32'(err_o), 32'd0);
    checkOutput("reset_regwrite", 32'(regwrite_o), 32'd0);
    checkOutput("reset_alu", alu_result_o, 32'd0);
    checkOutput("reset_memdata", mem_data_o, 32'd0);
    respEnable = 1'b1;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 5'd5, 0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h1003, 32'h0, 5'd9, 3, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h2004, 32'hA5A5A5A5, 5'd0, 0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h3008, 32'h0, 5'd3, 0, 32'h11223344);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h300C, 32'h55AA55AA, 5'd0, 0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h4001, 32'hCAFEF00D, 5'd4, 1, 32'h99999999);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h5000, 32'h0, 5'd6, T - 1, 32'h0BADF00D);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h6000, 32'h0, 5'd8, 100, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h7777, 32'h0, 5'd2, 0, 32'h0);

    // Reset in the second ACCESS cycle, then an ack that must be ignored.
    respEnable = 1'b0;
    mem_ack_i = 1'b0;
    regwrite_i = 1'b1; memtoreg_i = 1'b1; memread_i = 1'b1; memwrite_i = 1'b0;
    alu_result_i = 32'h8000; rs2_data_i = 32'h0; rd_addr_i = 5'd7;
    @(posedge clk_i);
    #1;
    regwrite_i = 1'b0; memtoreg_i = 1'b0; memread_i = 1'b0;
    alu_result_i = 32'h0; rd_addr_i = 5'd0;
    checkOutput("rst_test_req1", 32'(mem_req_o), 32'd1);
    @(posedge clk_i);
    #1;
    checkOutput("rst_test_req2", 32'(mem_req_o), 32'd1);
    checkOutput("rst_test_stall2", 32'(stall_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    expErr = 1'b0;
    checkOutput("rst_mid_req", 32'(mem_req_o), 32'd0);
    checkOutput("rst_mid_err", 32'(err_o), 32'd0);
    checkOutput("rst_mid_stall", 32'(stall_o), 32'd0);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h12345678;
    repeat (2) begin
      @(posedge clk_i);
      #1;
      checkOutput("late_ack_req", 32'(mem_req_o), 32'd0);
      checkOutput("late_ack_memdata", mem_data_o, 32'd0);
      checkOutput("late_ack_regwrite", 32'(regwrite_o), 32'd0);
    end
    mem_ack_i = 1'b0;
    respEnable = 1'b1;

    for (int i = 0; i < 150; i++) randomInstr();

    regwrite_i = 1'b0; memtoreg_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0;
    alu_result_i = 32'h0; rs2_data_i = 32'h0; rd_addr_i = 5'd0;
    repeat (4) @(posedge clk_i);
    #1;
    checkOutput("wb_queue_drained", 32'(expQ.size()), 32'd0);
    checkOutput("mem_queue_drained", 32'(memQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
